// File: rtl/shape_program_sequencer.sv
// shape_program_sequencer
// Head-of-chain controller for the shape renderer pipeline. Generates the raster
// scan beats and interleaves the five register-programming beats of each queued
// shape descriptor so that reprogramming never lands on a pixel beat.
// Build option: define SHAPE_SEQ_FRAME_SYNC_EN to defer all reprogramming to the
// frame boundary (shapes only change between frames).
//
// state      | meaning
// -----------+-----------------------------------------------------------------
// SCAN       | raster scan beats; leaves as soon as a descriptor may be programmed
// WAIT_FRAME | descriptor pending, scan keeps running until the frame_end beat
// PROG       | emitting program beats 0..4 of the current descriptor
module shape_program_sequencer #(
    parameter int          H_ACTIVE   = 1920,
    parameter int          V_ACTIVE   = 1080,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] BACKGROUND = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        desc_valid,
    output logic        desc_ready,
    input  logic [10:0] desc_shape_id,
    input  logic [10:0] desc_x,
    input  logic [11:0] desc_y,
    input  logic [10:0] desc_w,
    input  logic [11:0] desc_h,
    input  logic [31:0] desc_color,
    input  logic        scan_en,
    output logic        program_out,
    output logic [10:0] x_out,
    output logic [11:0] y_out,
    output logic [31:0] data_out,
    output logic        pixel_valid,
    output logic        frame_end,
    output logic        busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [10:0] X_LAST = 11'(H_ACTIVE - 1);
    localparam logic [11:0] Y_LAST = 12'(V_ACTIVE - 1);

`ifdef SHAPE_SEQ_FRAME_SYNC_EN
    localparam bit FRAME_SYNC = 1'b1;
`else
    localparam bit FRAME_SYNC = 1'b0;
`endif

    typedef struct packed {
        logic [10:0] shape_id;
        logic [10:0] x;
        logic [11:0] y;
        logic [10:0] w;
        logic [11:0] h;
        logic [31:0] color;
    } desc_t;

    typedef enum logic [1:0] {
        ST_SCAN       = 2'd0,
        ST_WAIT_FRAME = 2'd1,
        ST_PROG       = 2'd2
    } state_t;

    // descriptor FIFO
    desc_t             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_q, wr_d;
    logic [PTR_W-1:0]  rd_q, rd_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              desc_ready_q, desc_ready_d;
    logic              push, pop;
    logic              fifo_nonempty;
    desc_t             head;

    // sequencer state
    state_t            state_q, state_d;
    logic [2:0]        beat_q, beat_d;
    desc_t             cur_q, cur_d;
    logic [10:0]       x_cnt_q, x_cnt_d;
    logic [11:0]       y_cnt_q, y_cnt_d;
    logic [10:0]       last_x_q, last_x_d;
    logic [11:0]       last_y_q, last_y_d;
    logic              do_scan, emit_prog, sync_ok;

    // registered outputs
    logic              program_q, program_d;
    logic [10:0]       x_out_q, x_out_d;
    logic [11:0]       y_out_q, y_out_d;
    logic [31:0]       data_q, data_d;
    logic              pixel_valid_q, pixel_valid_d;
    logic              frame_end_q, frame_end_d;
    logic              busy_q, busy_d;

    assign push          = desc_valid && desc_ready_q;
    assign fifo_nonempty = (count_q != '0);
    assign head          = fifo_mem[rd_q];
    // With frame sync, a descriptor may only start right after the frame_end beat.
    assign sync_ok       = FRAME_SYNC ? frame_end_q : 1'b1;

    function automatic logic [31:0] beat_data(input desc_t d, input logic [2:0] idx);
        case (idx)
            3'd0:    beat_data = {21'd0, d.x};
            3'd1:    beat_data = {20'd0, d.y};
            3'd2:    beat_data = {21'd0, d.w};
            3'd3:    beat_data = {20'd0, d.h};
            default: beat_data = d.color;
        endcase
    endfunction

    // FIFO storage: written on an accepted push only, so no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_q] <= '{shape_id: desc_shape_id, x: desc_x, y: desc_y,
                                w: desc_w, h: desc_h, color: desc_color};
        end
    end

    // FIFO pointer/count next-state; ready is registered from the next count
    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (push) begin
            wr_d = wr_q + 1'b1;
        end
        if (pop) begin
            rd_d = rd_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        desc_ready_d = (count_d < DEPTH_C);
    end

    // FSM next state, raster counters and next output beat
    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        cur_d         = cur_q;
        x_cnt_d       = x_cnt_q;
        y_cnt_d       = y_cnt_q;
        last_x_d      = last_x_q;
        last_y_d      = last_y_q;
        pop           = 1'b0;
        do_scan       = 1'b0;
        emit_prog     = 1'b0;
        program_d     = 1'b0;
        x_out_d       = last_x_q;
        y_out_d       = last_y_q;
        data_d        = BACKGROUND;
        pixel_valid_d = 1'b0;
        frame_end_d   = 1'b0;

        case (state_q)
            ST_SCAN: begin
                if (fifo_nonempty && sync_ok) begin
                    state_d = ST_PROG;
                    pop     = 1'b1;
                end else begin
                    do_scan = 1'b1;
                    if (fifo_nonempty) begin
                        state_d = ST_WAIT_FRAME;
                    end
                end
            end
            ST_WAIT_FRAME: begin
                if (frame_end_q && fifo_nonempty) begin
                    state_d = ST_PROG;
                    pop     = 1'b1;
                end else begin
                    do_scan = 1'b1;
                end
            end
            ST_PROG: begin
                if (beat_q != 3'd4) begin
                    beat_d    = beat_q + 3'd1;
                    emit_prog = 1'b1;
                end else if (fifo_nonempty) begin
                    pop = 1'b1;
                end else begin
                    // Leaving PROG: this cycle already produces the first scan beat.
                    state_d = ST_SCAN;
                    do_scan = 1'b1;
                end
            end
            default: begin
                state_d = ST_SCAN;
            end
        endcase

        if (pop) begin
            cur_d     = head;
            beat_d    = 3'd0;
            emit_prog = 1'b1;
        end

        if (emit_prog) begin
            program_d = 1'b1;
            x_out_d   = cur_d.shape_id;
            y_out_d   = {9'd0, beat_d};
            data_d    = beat_data(cur_d, beat_d);
        end else if (do_scan && scan_en) begin
            pixel_valid_d = 1'b1;
            x_out_d       = x_cnt_q;
            y_out_d       = y_cnt_q;
            last_x_d      = x_cnt_q;
            last_y_d      = y_cnt_q;
            if (x_cnt_q == X_LAST) begin
                x_cnt_d = '0;
                if (y_cnt_q == Y_LAST) begin
                    y_cnt_d     = '0;
                    frame_end_d = 1'b1;
                end else begin
                    y_cnt_d = y_cnt_q + 12'd1;
                end
            end else begin
                x_cnt_d = x_cnt_q + 11'd1;
            end
        end

        busy_d = (count_d != '0) || (state_d == ST_PROG);
    end

    // state, FIFO control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q          <= '0;
            rd_q          <= '0;
            count_q       <= '0;
            desc_ready_q  <= 1'b1;
            state_q       <= ST_SCAN;
            beat_q        <= '0;
            cur_q         <= '0;
            x_cnt_q       <= '0;
            y_cnt_q       <= '0;
            last_x_q      <= '0;
            last_y_q      <= '0;
            program_q     <= 1'b0;
            x_out_q       <= '0;
            y_out_q       <= '0;
            data_q        <= '0;
            pixel_valid_q <= 1'b0;
            frame_end_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            wr_q          <= wr_d;
            rd_q          <= rd_d;
            count_q       <= count_d;
            desc_ready_q  <= desc_ready_d;
            state_q       <= state_d;
            beat_q        <= beat_d;
            cur_q         <= cur_d;
            x_cnt_q       <= x_cnt_d;
            y_cnt_q       <= y_cnt_d;
            last_x_q      <= last_x_d;
            last_y_q      <= last_y_d;
            program_q     <= program_d;
            x_out_q       <= x_out_d;
            y_out_q       <= y_out_d;
            data_q        <= data_d;
            pixel_valid_q <= pixel_valid_d;
            frame_end_q   <= frame_end_d;
            busy_q        <= busy_d;
        end
    end

    assign desc_ready  = desc_ready_q;
    assign program_out = program_q;
    assign x_out       = x_out_q;
    assign y_out       = y_out_q;
    assign data_out    = data_q;
    assign pixel_valid = pixel_valid_q;
    assign frame_end   = frame_end_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_shape_program_sequencer.sv
// Testbench for shape_program_sequencer: small raster (4x2), depth-4 FIFO,
// random traffic compared beat by beat with a queue-based reference model.
module tb_shape_program_sequencer;

    localparam int          H     = 4;
    localparam int          V     = 2;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BG    = 32'hA5A5_0001;
`ifdef SHAPE_SEQ_FRAME_SYNC_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        desc_valid = 1'b0;
    logic        desc_ready;
    logic [10:0] desc_shape_id = '0;
    logic [10:0] desc_x = '0;
    logic [11:0] desc_y = '0;
    logic [10:0] desc_w = '0;
    logic [11:0] desc_h = '0;
    logic [31:0] desc_color = '0;
    logic        scan_en = 1'b0;
    logic        program_out;
    logic [10:0] x_out;
    logic [11:0] y_out;
    logic [31:0] data_out;
    logic        pixel_valid;
    logic        frame_end;
    logic        busy;

    always #5 clk = ~clk;

    shape_program_sequencer #(
        .H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(DEPTH), .BACKGROUND(BG)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_shape_id(desc_shape_id), .desc_x(desc_x), .desc_y(desc_y),
        .desc_w(desc_w), .desc_h(desc_h), .desc_color(desc_color),
        .scan_en(scan_en), .program_out(program_out),
        .x_out(x_out), .y_out(y_out), .data_out(data_out),
        .pixel_valid(pixel_valid), .frame_end(frame_end), .busy(busy)
    );

    // reference model: pending descriptors as a queue, raster as plain integers
    typedef struct {
        int          id;
        int          x;
        int          y;
        int          w;
        int          h;
        logic [31:0] color;
    } mdesc_t;

    mdesc_t      m_q[$];
    mdesc_t      m_cur;
    bit          m_prog;
    int          m_beat;
    int          m_px, m_py, m_lx, m_ly;
    logic        e_prog, e_pv, e_fe, e_busy, e_ready;
    logic [10:0] e_x;
    logic [11:0] e_y;
    logic [31:0] e_data;

    int total = 0;
    int bad   = 0;

    function automatic logic [59:0] dut_vec();
        return {program_out, pixel_valid, frame_end, busy, desc_ready, x_out, y_out, data_out};
    endfunction

    function automatic logic [59:0] model_vec();
        return {e_prog, e_pv, e_fe, e_busy, e_ready, e_x, e_y, e_data};
    endfunction

    function automatic logic [31:0] reg_word(input mdesc_t d, input int b);
        if (b == 0) return 32'(d.x);
        if (b == 1) return 32'(d.y);
        if (b == 2) return 32'(d.w);
        if (b == 3) return 32'(d.h);
        return d.color;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_prog = 1'b0;
        m_beat = 0;
        m_px = 0; m_py = 0; m_lx = 0; m_ly = 0;
        e_prog = 1'b0; e_pv = 1'b0; e_fe = 1'b0; e_busy = 1'b0; e_ready = 1'b1;
        e_x = '0; e_y = '0; e_data = '0;
    endtask

    // Predict the beat produced by the next clock edge from the current inputs.
    task automatic model_step();
        bit     push_m;
        bit     fe_prev;
        mdesc_t nd;
        push_m   = desc_valid && e_ready;
        nd.id    = desc_shape_id;
        nd.x     = desc_x;
        nd.y     = desc_y;
        nd.w     = desc_w;
        nd.h     = desc_h;
        nd.color = desc_color;
        fe_prev  = e_fe;
        e_prog = 1'b0; e_pv = 1'b0; e_fe = 1'b0;
        e_x = 11'(m_lx); e_y = 12'(m_ly); e_data = BG;
        if (m_prog && m_beat < 4) begin
            m_beat++;
            e_prog = 1'b1;
        end else if (m_q.size() > 0 && (m_prog || !SYNC || fe_prev)) begin
            m_cur  = m_q.pop_front();
            m_beat = 0;
            m_prog = 1'b1;
            e_prog = 1'b1;
        end else begin
            m_prog = 1'b0;
            if (scan_en) begin
                e_pv = 1'b1;
                e_x  = 11'(m_px);
                e_y  = 12'(m_py);
                m_lx = m_px;
                m_ly = m_py;
                e_fe = (m_px == H - 1) && (m_py == V - 1);
                m_px++;
                if (m_px == H) begin
                    m_px = 0;
                    m_py++;
                    if (m_py == V) m_py = 0;
                end
            end
        end
        if (e_prog) begin
            e_x    = 11'(m_cur.id);
            e_y    = 12'(m_beat);
            e_data = reg_word(m_cur, m_beat);
        end
        if (push_m) m_q.push_back(nd);
        e_ready = (m_q.size() < DEPTH);
        e_busy  = (m_q.size() > 0) || m_prog;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n      = 1'b0;
        desc_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic rand_desc();
        desc_shape_id = 11'($urandom_range(0, 2047));
        desc_x        = 11'($urandom_range(0, 2047));
        desc_y        = 12'($urandom_range(0, 4095));
        desc_w        = 11'($urandom_range(0, 2047));
        desc_h        = 12'($urandom_range(0, 4095));
        desc_color    = $urandom;
    endtask

    task automatic test_reset();
        logic [59:0] rst_vec;
        rst_vec    = {5'b00001, 55'd0};
        rst_n      = 1'b0;
        scan_en    = 1'b1;
        desc_valid = 1'b1;
        rand_desc();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (dut_vec() !== rst_vec) begin
                bad++;
                $display("FAIL reset_values cyc=%0d got=%h exp=%h", i, dut_vec(), rst_vec);
            end
            total++;
        end
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 10; i++) begin
            tick();
            desc_valid = 1'b0;
            if (dut_vec() !== model_vec()) begin
                bad++;
                $display("FAIL reset_release cyc=%0d got=%h exp=%h", i, dut_vec(), model_vec());
            end
            total++;
        end
    endtask

    task automatic test_scan_raster();
        int fe_cnt;
        apply_reset();
        scan_en = 1'b1;
        fe_cnt  = 0;
        for (int i = 0; i < 18; i++) begin
            tick();
            if (dut_vec() !== model_vec()) begin
                bad++;
                $display("FAIL scan_raster cyc=%0d got=%h exp=%h", i, dut_vec(), model_vec());
            end
            total++;
            if (frame_end) begin
                fe_cnt++;
                if (x_out !== 11'd3 || y_out !== 12'd1) begin
                    bad++;
                    $display("FAIL frame_end_pos got=(%0d,%0d) exp=(3,1)", x_out, y_out);
                end
                total++;
            end
        end
        if (fe_cnt != 2) begin
            bad++;
            $display("FAIL frame_end_count got=%0d exp=2", fe_cnt);
        end
        total++;
    endtask

    task automatic test_single_desc();
        logic [31:0] got[5];
        logic [31:0] want[5];
        int          n;
        bit          resumed;
        want[0] = 32'd100; want[1] = 32'd200; want[2] = 32'd50;
        want[3] = 32'd25;  want[4] = 32'hFF00FF00;
        apply_reset();
        scan_en = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        desc_valid = 1'b1;
        desc_shape_id = 11'd3; desc_x = 11'd100; desc_y = 12'd200;
        desc_w = 11'd50; desc_h = 12'd25; desc_color = 32'hFF00FF00;
        n       = 0;
        resumed = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            desc_valid = 1'b0;
            if (dut_vec() !== model_vec()) begin
                bad++;
                $display("FAIL single_desc cyc=%0d got=%h exp=%h", i, dut_vec(), model_vec());
            end
            total++;
            if (program_out) begin
                if (n < 5) got[n] = data_out;
                if (x_out !== 11'd3 || y_out !== 12'(n)) begin
                    bad++;
                    $display("FAIL single_desc_ids beat=%0d got=(%0d,%0d) exp=(3,%0d)", n, x_out, y_out, n);
                end
                total++;
                n++;
            end else if (n == 5 && !resumed) begin
                resumed = 1'b1;
                if (x_out !== 11'd0 || y_out !== 12'd1 || pixel_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL single_desc_resume got=(%0d,%0d,pv=%0d) exp=(0,1,pv=1)", x_out, y_out, pixel_valid);
                end
                total++;
            end
        end
        if (n != 5) begin
            bad++;
            $display("FAIL single_desc_beats got=%0d exp=5", n);
        end
        total++;
        for (int b = 0; b < 5; b++) begin
            if (b < n && got[b] !== want[b]) begin
                bad++;
                $display("FAIL single_desc_data beat=%0d got=%h exp=%h", b, got[b], want[b]);
            end
            total++;
        end
    endtask

    task automatic test_fifo_full();
        bit ready_low;
        bit accepted;
        int beats;
        int ids[$];
        apply_reset();
        scan_en   = 1'b0;
        ready_low = 1'b0;
        beats     = 0;
        for (int k = 0; k < 6; k++) begin
            rand_desc();
            desc_shape_id = 11'(20 + k);
            desc_valid    = 1'b1;
            accepted      = 1'b0;
            for (int t = 0; t < 20 && !accepted; t++) begin
                accepted = desc_ready;
                if (!desc_ready) ready_low = 1'b1;
                tick();
                if (dut_vec() !== model_vec()) begin
                    bad++;
                    $display("FAIL fifo_full k=%0d got=%h exp=%h", k, dut_vec(), model_vec());
                end
                total++;
                if (program_out) begin
                    beats++;
                    if (y_out == 12'd0) ids.push_back(int'(x_out));
                end
            end
            if (!accepted) begin
                bad++;
                $display("FAIL fifo_full_accept k=%0d got=timeout exp=accepted", k);
            end
            total++;
        end
        desc_valid = 1'b0;
        for (int t = 0; t < 40; t++) begin
            tick();
            if (dut_vec() !== model_vec()) begin
                bad++;
                $display("FAIL fifo_drain cyc=%0d got=%h exp=%h", t, dut_vec(), model_vec());
            end
            total++;
            if (program_out) begin
                beats++;
                if (y_out == 12'd0) ids.push_back(int'(x_out));
            end
        end
        if (!ready_low) begin
            bad++;
            $display("FAIL fifo_ready_low got=never exp=low_when_full");
        end
        total++;
        if (beats != 30) begin
            bad++;
            $display("FAIL fifo_beats got=%0d exp=30", beats);
        end
        total++;
        for (int k = 0; k < 6; k++) begin
            if (k >= ids.size() || ids[k] != 20 + k) begin
                bad++;
                $display("FAIL fifo_order idx=%0d got=%0d exp=%0d", k, (k < ids.size()) ? ids[k] : -1, 20 + k);
            end
            total++;
        end
    endtask

    task automatic test_back_to_back();
        int run, best;
        apply_reset();
        scan_en = 1'b1;
        run  = 0;
        best = 0;
        for (int i = 0; i < 16; i++) begin
            if (i < 2) begin
                rand_desc();
                desc_valid = 1'b1;
            end else begin
                desc_valid = 1'b0;
            end
            tick();
            if (dut_vec() !== model_vec()) begin
                bad++;
                $display("FAIL back_to_back cyc=%0d got=%h exp=%h", i, dut_vec(), model_vec());
            end
            total++;
            run  = program_out ? run + 1 : 0;
            best = (run > best) ? run : best;
        end
        if (best != 10) begin
            bad++;
            $display("FAIL back_to_back_run got=%0d exp=10", best);
        end
        total++;
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            rand_desc();
            desc_valid = ($urandom_range(0, 99) < 30);
            scan_en    = ($urandom_range(0, 99) < 70);
            tick();
            if (dut_vec() !== model_vec()) begin
                bad++;
                $display("FAIL random cyc=%0d got=%h exp=%h", i, dut_vec(), model_vec());
            end
            total++;
        end
        desc_valid = 1'b0;
    endtask

    task automatic test_reset_mid_prog();
        bit hit;
        apply_reset();
        scan_en = 1'b1;
        rand_desc();
        desc_valid = 1'b1;
        tick();
        desc_valid = 1'b1;
        rand_desc();
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            tick();
            desc_valid = 1'b0;
            hit = m_prog && (m_beat == 2);
        end
        if (!hit) begin
            bad++;
            $display("FAIL mid_prog_reach got=timeout exp=beat2");
        end
        total++;
        if (program_out !== 1'b1 || y_out !== 12'd2) begin
            bad++;
            $display("FAIL mid_prog_beat got=(prog=%0d,y=%0d) exp=(prog=1,y=2)", program_out, y_out);
        end
        total++;
        #2;
        rst_n = 1'b0;
        #1;
        if (dut_vec() !== {5'b00001, 55'd0}) begin
            bad++;
            $display("FAIL mid_prog_async got=%h exp=%h", dut_vec(), {5'b00001, 55'd0});
        end
        total++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            tick();
            if (dut_vec() !== model_vec()) begin
                bad++;
                $display("FAIL mid_prog_after cyc=%0d got=%h exp=%h", i, dut_vec(), model_vec());
            end
            total++;
            if (i == 0 && (x_out !== 11'd0 || y_out !== 12'd0 || pixel_valid !== 1'b1 || busy !== 1'b0)) begin
                bad++;
                $display("FAIL mid_prog_restart got=(%0d,%0d,pv=%0d,busy=%0d) exp=(0,0,pv=1,busy=0)",
                         x_out, y_out, pixel_valid, busy);
            end
            if (i == 0) total++;
        end
    endtask

    task automatic test_frame_sync();
        bit prev_fe;
        bit seen_prog;
        apply_reset();
        scan_en   = 1'b1;
        prev_fe   = 1'b0;
        seen_prog = 1'b0;
        tick();
        rand_desc();
        desc_valid = 1'b1;
        for (int i = 0; i < 24; i++) begin
            tick();
            desc_valid = 1'b0;
            if (dut_vec() !== model_vec()) begin
                bad++;
                $display("FAIL frame_sync cyc=%0d got=%h exp=%h", i, dut_vec(), model_vec());
            end
            total++;
            if (program_out && y_out == 12'd0 && !seen_prog) begin
                seen_prog = 1'b1;
                if (!prev_fe) begin
                    bad++;
                    $display("FAIL frame_sync_start got=no_frame_end_before exp=frame_end_before");
                end
                total++;
            end
            prev_fe = frame_end;
        end
        if (!seen_prog) begin
            bad++;
            $display("FAIL frame_sync_prog got=none exp=program_beats");
        end
        total++;
    endtask

    initial begin
        test_reset();
        test_scan_raster();
`ifdef SHAPE_SEQ_FRAME_SYNC_EN
        test_frame_sync();
`else
        test_single_desc();
        test_fifo_full();
        test_back_to_back();
`endif
        test_random();
        test_reset_mid_prog();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
